// File: rtl/agc_shift_ctrl.sv
// Automatic gain control for the DDC shift/round stage: tracks the peak I/Q magnitude per
// window of nd samples and steers the left-shift amount to keep MARGIN bits of headroom.
module agc_shift_ctrl #(
  parameter int unsigned INPUT_WIDTH = 27,
  parameter int unsigned ADJ_WIDTH   = 11,
  parameter int unsigned ADJ_MAX     = 16,
  parameter int unsigned INIT_ADJ    = 0,
  parameter int unsigned MARGIN      = 1,
  parameter int unsigned WIN_LOG2    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   agc_en,
  input  logic [ADJ_WIDTH-1:0]   man_adjust,
  input  logic [INPUT_WIDTH-1:0] data_in_i,
  input  logic [INPUT_WIDTH-1:0] data_in_q,
  input  logic                   nd,
  output logic [ADJ_WIDTH-1:0]   adjust,
  output logic                   adj_upd,
  output logic                   win_clip,
  output logic [4:0]             peak_hr
);

  localparam int unsigned MagW = INPUT_WIDTH - 1;
  localparam logic [INPUT_WIDTH-1:0] ThrOne = INPUT_WIDTH'(1);

  // A window end must never land in CALC/APPLY, which needs windows of at least 4 samples.
  if (WIN_LOG2 < 2 || ADJ_MAX >= INPUT_WIDTH || INPUT_WIDTH > 32) begin : gen_param_err
    $error("agc_shift_ctrl: unsupported parameter combination");
  end

  typedef enum logic [1:0] {StManual, StAccum, StCalc, StApply} state_e;

  state_e                 state_q, state_d;
  logic [ADJ_WIDTH-1:0]   adjust_q, adjust_d, man_clamped;
  logic                   adj_upd_q, adj_upd_d, win_clip_q, win_clip_d;
  logic [4:0]             peak_hr_q, peak_hr_d, hr_d, hr_q;
  logic [ADJ_WIDTH-1:0]   desired_d, desired_q;

  logic [MagW-1:0]        abs_i, abs_q, mag_d, mag_q;
  logic                   mag_vld_q;
  logic [INPUT_WIDTH-1:0] clip_thr;
  logic                   clip, clip_cur, first, win_end, enter;
  logic [WIN_LOG2-1:0]    cnt_q;
  logic [MagW-1:0]        peak_q, peak_cur, peak_hold_q;
  logic                   clip_flag_q, clip_hold_q, win_end_q;
  int                     msb, hr_int, des_int;

  // Ones-complement magnitude avoids overflow at the most negative input.
  always_comb begin
    abs_i = data_in_i[INPUT_WIDTH-1] ? ~data_in_i[MagW-1:0] : data_in_i[MagW-1:0];
    abs_q = data_in_q[INPUT_WIDTH-1] ? ~data_in_q[MagW-1:0] : data_in_q[MagW-1:0];
    mag_d = (abs_i > abs_q) ? abs_i : abs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q     <= '0;
      mag_vld_q <= 1'b0;
    end else begin
      mag_vld_q <= nd;
      if (nd) mag_q <= mag_d;
    end
  end

  assign clip_thr = ThrOne << (MagW - int'(adjust_q));
  assign clip     = mag_vld_q && ({1'b0, mag_q} >= clip_thr);
  assign first    = (cnt_q == '0);
  assign peak_cur = (first || (mag_q > peak_q)) ? mag_q : peak_q;
  assign clip_cur = clip | (clip_flag_q & ~first);
  assign win_end  = mag_vld_q && (cnt_q == '1);
  assign enter    = (state_q == StManual) && agc_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      peak_q      <= '0;
      peak_hold_q <= '0;
      clip_flag_q <= 1'b0;
      clip_hold_q <= 1'b0;
      win_end_q   <= 1'b0;
    end else if (enter) begin
      cnt_q       <= '0;
      peak_q      <= '0;
      clip_flag_q <= 1'b0;
      win_end_q   <= 1'b0;
    end else begin
      win_end_q <= win_end;
      if (mag_vld_q) begin
        cnt_q       <= cnt_q + 1'b1;
        peak_q      <= peak_cur;
        clip_flag_q <= clip_cur;
        if (win_end) begin
          peak_hold_q <= peak_cur;
          clip_hold_q <= clip_cur;
        end
      end
    end
  end

  // Headroom of the held peak and the shift that leaves MARGIN bits of it unused.
  always_comb begin
    msb = 0;
    for (int b = 0; b < int'(MagW); b++) begin
      if (peak_hold_q[b]) msb = b;
    end
    hr_int  = (peak_hold_q == '0) ? int'(INPUT_WIDTH) - 1 : int'(INPUT_WIDTH) - 2 - msb;
    des_int = hr_int - int'(MARGIN);
    if (des_int < 0) des_int = 0;
    else if (des_int > int'(ADJ_MAX)) des_int = int'(ADJ_MAX);
    hr_d      = 5'(hr_int);
    desired_d = ADJ_WIDTH'(des_int);
  end

  assign man_clamped = (man_adjust > ADJ_WIDTH'(ADJ_MAX)) ? ADJ_WIDTH'(ADJ_MAX) : man_adjust;

  always_comb begin
    state_d    = state_q;
    adjust_d   = adjust_q;
    adj_upd_d  = 1'b0;
    win_clip_d = win_clip_q;
    peak_hr_d  = peak_hr_q;
    if (!agc_en) begin
      state_d  = StManual;
      adjust_d = man_clamped;
    end else begin
      case (state_q)
        StManual: state_d = StAccum;
        StAccum:  if (win_end_q) state_d = StCalc;
        StCalc:   state_d = StApply;
        StApply: begin
          state_d    = StAccum;
          adj_upd_d  = 1'b1;
          win_clip_d = clip_hold_q;
          peak_hr_d  = hr_q;
          // Fast attack on clipping or lower target, one-step decay otherwise.
          if ((desired_q < adjust_q) || clip_hold_q) begin
            adjust_d = (desired_q < adjust_q) ? desired_q : adjust_q;
          end else if (desired_q > adjust_q) begin
            adjust_d = adjust_q + 1'b1;
          end
        end
        default: state_d = StManual;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StManual;
      adjust_q   <= ADJ_WIDTH'(INIT_ADJ);
      adj_upd_q  <= 1'b0;
      win_clip_q <= 1'b0;
      peak_hr_q  <= '0;
      hr_q       <= '0;
      desired_q  <= '0;
    end else begin
      state_q    <= state_d;
      adjust_q   <= adjust_d;
      adj_upd_q  <= adj_upd_d;
      win_clip_q <= win_clip_d;
      peak_hr_q  <= peak_hr_d;
      hr_q       <= hr_d;
      desired_q  <= desired_d;
    end
  end

  assign adjust   = adjust_q;
  assign adj_upd  = adj_upd_q;
  assign win_clip = win_clip_q;
  assign peak_hr  = peak_hr_q;

endmodule
